// File: rtl/sobel_window_scanner.sv
// Raster scanner for a 3x3 Sobel window: issues nine tap reads, a drain cycle and
// one centre write per interior pixel, driven by the controller's Reset/Enable commands.
module sobel_window_scanner #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              Begin,
  input  logic              Reset,
  input  logic              Enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        tap_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              isEnd,
  output logic              busy
);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 2);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [3:0]        phase_q, phase_d;
  logic [1:0]        ky, kx;
  logic [ADDR_W-1:0] rdAddr_d, wrAddr_d;
  logic              rdEn_d, wrEn_d;

  logic              rdEn_q, wrEn_q, isEnd_q, busy_q;
  logic [ADDR_W-1:0] rdAddr_q, wrAddr_q;
  logic [3:0]        tapIdx_q;

  // Enable outranks Reset; a bare Reset clears, neither holds everything.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    phase_d = phase_q;
    if (Enable) begin
      case (state_q)
        IDLE: begin
          state_d = READ;
          phase_d = 4'd0;
        end
        READ: begin
          if (phase_q == 4'd8) state_d = DRAIN;
          else                 phase_d = phase_q + 4'd1;
        end
        DRAIN: state_d = WRITE;
        WRITE: begin
          phase_d = 4'd0;
          if (col_q < COL_LAST) begin
            col_d   = col_q + COL_W'(1);
            state_d = READ;
          end else if (row_q < ROW_LAST) begin
            col_d   = COL_W'(1);
            row_d   = row_q + ROW_W'(1);
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end else if (Reset) begin
      state_d = IDLE;
      row_d   = ROW_W'(1);
      col_d   = COL_W'(1);
      phase_d = 4'd0;
    end
  end

  // Outputs are decoded from the next state so they are registered; strobes only
  // fire on cycles entered by an enabled step, which keeps them low while frozen.
  always_comb begin
    if (phase_d >= 4'd6)      ky = 2'd2;
    else if (phase_d >= 4'd3) ky = 2'd1;
    else                      ky = 2'd0;
    kx       = 2'(phase_d - 4'(ky) * 4'd3);
    rdAddr_d = (ADDR_W'(row_d) + ADDR_W'(ky) - ADDR_W'(1)) * ADDR_W'(IMG_W)
             + ADDR_W'(col_d) + ADDR_W'(kx) - ADDR_W'(1);
    wrAddr_d = ADDR_W'(row_d) * ADDR_W'(IMG_W) + ADDR_W'(col_d);
    rdEn_d   = Enable && (state_d == READ);
    wrEn_d   = Enable && (state_d == WRITE);
  end

  always_ff @(posedge CLK) begin
    if (Begin) begin
      state_q  <= IDLE;
      row_q    <= ROW_W'(1);
      col_q    <= COL_W'(1);
      phase_q  <= 4'd0;
      rdEn_q   <= 1'b0;
      rdAddr_q <= '0;
      tapIdx_q <= 4'd0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      isEnd_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      phase_q  <= phase_d;
      rdEn_q   <= rdEn_d;
      rdAddr_q <= rdEn_d ? rdAddr_d : '0;
      tapIdx_q <= rdEn_d ? phase_d : 4'd0;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrEn_d ? wrAddr_d : '0;
      isEnd_q  <= (state_d == DONE);
      busy_q   <= (state_d == READ) || (state_d == DRAIN) || (state_d == WRITE);
    end
  end

  assign rd_en   = rdEn_q;
  assign rd_addr = rdAddr_q;
  assign tap_idx = tapIdx_q;
  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign isEnd   = isEnd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sobel_window_scanner.sv
// Scoreboard bench: a 4x4 and a 5x4 scanner, expected reads/writes queued by stimulus
// and consumed by per-instance monitors on the falling edge.
module tb_sobel_window_scanner;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic beginR, rstA, enA, rstB, enB;
  logic          rdEnA, wrEnA, isEndA, busyA;
  logic [AW-1:0] rdAddrA, wrAddrA;
  logic [3:0]    tapA;
  logic          rdEnB, wrEnB, isEndB, busyB;
  logic [AW-1:0] rdAddrB, wrAddrB;
  logic [3:0]    tapB;

  sobel_window_scanner #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) dutA (
    .CLK(clk), .Begin(beginR), .Reset(rstA), .Enable(enA),
    .rd_en(rdEnA), .rd_addr(rdAddrA), .tap_idx(tapA),
    .wr_en(wrEnA), .wr_addr(wrAddrA), .isEnd(isEndA), .busy(busyA)
  );

  sobel_window_scanner #(.IMG_W(5), .IMG_H(4), .ADDR_W(AW)) dutB (
    .CLK(clk), .Begin(beginR), .Reset(rstB), .Enable(enB),
    .rd_en(rdEnB), .rd_addr(rdAddrB), .tap_idx(tapB),
    .wr_en(wrEnB), .wr_addr(wrAddrB), .isEnd(isEndB), .busy(busyB)
  );

  typedef struct packed {
    logic [3:0]    tap;
    logic [AW-1:0] addr;
  } rdExp_t;

  rdExp_t        rdQA[$], rdQB[$];
  logic [AW-1:0] wrQA[$], wrQB[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lastWrA = -1;
  bit gapCheckA = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input bit b, input bit ra, input bit ea,
                               input bit rb, input bit eb, input int n);
    beginR = b;
    rstA = ra;
    enA = ea;
    rstB = rb;
    enB = eb;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the nine tap reads of one window centre (row r, column c) of a w-wide frame.
  task automatic pushReads(input bit toB, input int r, input int c, input int w);
    rdExp_t e;
    for (int t = 0; t < 9; t++) begin
      e.tap  = 4'(t);
      e.addr = AW'((r - 1 + t / 3) * w + (c - 1 + t % 3));
      if (toB) rdQB.push_back(e);
      else     rdQA.push_back(e);
    end
  endtask

  initial begin : monA
    rdExp_t e;
    forever begin
      @(negedge clk);
      if (rdEnA === 1'b1) begin
        checkOutput("A rd_en expected", int'(rdEnA), int'(rdQA.size() > 0));
        if (rdQA.size() > 0) begin
          e = rdQA.pop_front();
          checkOutput("A rd_addr", int'(rdAddrA), int'(e.addr));
          checkOutput("A tap_idx", int'(tapA), int'(e.tap));
        end
      end
      if (wrEnA === 1'b1) begin
        checkOutput("A wr_en expected", int'(wrEnA), int'(wrQA.size() > 0));
        if (wrQA.size() > 0) checkOutput("A wr_addr", int'(wrAddrA), int'(wrQA.pop_front()));
        if (gapCheckA && lastWrA >= 0) checkOutput("A wr spacing", cycle - lastWrA, 11);
        lastWrA = cycle;
      end
    end
  end

  initial begin : monB
    rdExp_t e;
    forever begin
      @(negedge clk);
      if (rdEnB === 1'b1) begin
        checkOutput("B rd_en expected", int'(rdEnB), int'(rdQB.size() > 0));
        if (rdQB.size() > 0) begin
          e = rdQB.pop_front();
          checkOutput("B rd_addr", int'(rdAddrB), int'(e.addr));
          checkOutput("B tap_idx", int'(tapB), int'(e.tap));
        end
      end
      if (wrEnB === 1'b1) begin
        checkOutput("B wr_en expected", int'(wrEnB), int'(wrQB.size() > 0));
        if (wrQB.size() > 0) checkOutput("B wr_addr", int'(wrAddrB), int'(wrQB.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int wrA[4];
    int wrB[6];
    wrA = '{5, 6, 9, 10};
    wrB = '{6, 7, 8, 11, 12, 13};

    // Reset with Enable asserted: everything must stay at zero.
    applyStimulus(1, 0, 1, 0, 1, 2);
    checkOutput("rst A rd_en", int'(rdEnA), 0);
    checkOutput("rst A rd_addr", int'(rdAddrA), 0);
    checkOutput("rst A tap_idx", int'(tapA), 0);
    checkOutput("rst A wr_en", int'(wrEnA), 0);
    checkOutput("rst A wr_addr", int'(wrAddrA), 0);
    checkOutput("rst A isEnd", int'(isEndA), 0);
    checkOutput("rst A busy", int'(busyA), 0);
    checkOutput("rst B rd_en", int'(rdEnB), 0);
    checkOutput("rst B busy", int'(busyB), 0);
    applyStimulus(0, 1, 0, 1, 0, 2);
    checkOutput("clear A busy", int'(busyA), 0);
    checkOutput("clear A isEnd", int'(isEndA), 0);
    checkOutput("clear A rd_en", int'(rdEnA), 0);

    // Full 4x4 frame, Reset held high alongside Enable after the first step.
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= 2; c++) pushReads(1'b0, r, c, 4);
    foreach (wrA[i]) wrQA.push_back(AW'(wrA[i]));
    gapCheckA = 1'b1;
    lastWrA = -1;
    applyStimulus(0, 0, 1, 1, 0, 1);
    checkOutput("A first rd_en", int'(rdEnA), 1);
    checkOutput("A busy running", int'(busyA), 1);
    applyStimulus(0, 1, 1, 1, 0, 43);
    checkOutput("A isEnd at 44", int'(isEndA), 0);
    applyStimulus(0, 1, 1, 1, 0, 1);
    checkOutput("A isEnd at 45", int'(isEndA), 1);
    checkOutput("A busy done", int'(busyA), 0);
    applyStimulus(0, 1, 1, 1, 0, 3);
    checkOutput("A isEnd held", int'(isEndA), 1);
    applyStimulus(0, 1, 0, 1, 0, 1);
    checkOutput("A isEnd cleared", int'(isEndA), 0);
    checkOutput("A busy cleared", int'(busyA), 0);
    checkOutput("A frame reads left", rdQA.size(), 0);
    checkOutput("A frame writes left", wrQA.size(), 0);

    // Abort during the first WRITE, then restart from the top.
    gapCheckA = 1'b0;
    pushReads(1'b0, 1, 1, 4);
    wrQA.push_back(AW'(5));
    applyStimulus(0, 0, 1, 1, 0, 11);
    checkOutput("A abort wr_en before", int'(wrEnA), 1);
    applyStimulus(0, 1, 0, 1, 0, 1);
    checkOutput("A abort wr_en after", int'(wrEnA), 0);
    checkOutput("A abort busy", int'(busyA), 0);
    checkOutput("A abort rd_en", int'(rdEnA), 0);
    pushReads(1'b0, 1, 1, 4);
    wrQA.push_back(AW'(5));
    applyStimulus(0, 0, 1, 1, 0, 1);
    checkOutput("A restart rd_addr", int'(rdAddrA), 0);
    applyStimulus(0, 0, 1, 1, 0, 10);
    checkOutput("A restart wr_addr", int'(wrAddrA), 5);
    applyStimulus(0, 1, 0, 1, 0, 1);
    checkOutput("A abort reads left", rdQA.size(), 0);
    checkOutput("A abort writes left", wrQA.size(), 0);

    // 5x4 frame with a freeze just before tap 4 of centre (1,2).
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= 3; c++) pushReads(1'b1, r, c, 5);
    foreach (wrB[i]) wrQB.push_back(AW'(wrB[i]));
    applyStimulus(0, 1, 0, 0, 1, 15);
    checkOutput("B pre-freeze tap", int'(tapB), 3);
    checkOutput("B pre-freeze rd_addr", int'(rdAddrB), 6);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 1);
      checkOutput("B frozen rd_en", int'(rdEnB), 0);
      checkOutput("B frozen busy", int'(busyB), 1);
    end
    applyStimulus(0, 1, 0, 0, 1, 1);
    checkOutput("B resume rd_addr", int'(rdAddrB), 7);
    checkOutput("B resume tap", int'(tapB), 4);
    applyStimulus(0, 1, 0, 0, 1, 50);
    checkOutput("B isEnd at 66", int'(isEndB), 0);
    applyStimulus(0, 1, 0, 0, 1, 1);
    checkOutput("B isEnd at 67", int'(isEndB), 1);
    applyStimulus(0, 1, 0, 1, 0, 2);
    checkOutput("B frame reads left", rdQB.size(), 0);
    checkOutput("B frame writes left", wrQB.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
